// File: rtl/systolic_feeder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : systolic_feeder                                            |
// | Description : Input-side sequencer for an N_SIZE x N_SIZE output-        |
// |               stationary systolic array. Buffers complete matrices A and |
// |               B, clears the array accumulators, then drives the          |
// |               diagonal-skewed per-row A / per-column B operand streams   |
// |               and pulses done when the array result is final.            |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
// | Ports                                                                    |
// |   clk         in   clock, all state on the rising edge                   |
// |   rst         in   asynchronous active-high reset                        |
// |   load_valid  in   load beat valid                                       |
// |   load_ready  out  beat accepted when load_valid && load_ready           |
// |   load_a      in   row k of A, A[k][m] at bits [m*DW +: DW]              |
// |   load_b      in   row k of B, B[k][m] at bits [m*DW +: DW]              |
// |   acc_clr_n   out  active-low accumulator clear to the array PEs         |
// |   feed_valid  out  high while skewed feed steps are driven               |
// |   feed_a      out  element i drives array row i                          |
// |   feed_b      out  element j drives array column j                       |
// |   done        out  one-cycle pulse, array result final this cycle        |
// +--------------------------------------------------------------------------+
module systolic_feeder #(
  parameter int DATAWIDTH = 16,
  parameter int N_SIZE    = 5
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               load_valid,
  output logic                               load_ready,
  input  logic [N_SIZE*DATAWIDTH-1:0]        load_a,
  input  logic [N_SIZE*DATAWIDTH-1:0]        load_b,
  output logic                               acc_clr_n,
  output logic                               feed_valid,
  output logic [N_SIZE-1:0][DATAWIDTH-1:0]   feed_a,
  output logic [N_SIZE-1:0][DATAWIDTH-1:0]   feed_b,
  output logic                               done
);

  // One counter serves beats (0..N-1), feed steps (0..2N-2) and flush
  // cycles (0..N-2); 2N-2 is the largest value it ever holds.
  localparam int CW = $clog2(2 * N_SIZE);

  localparam logic [CW-1:0] c_LAST_BEAT  = CW'(N_SIZE - 1);
  localparam logic [CW-1:0] c_LAST_STEP  = CW'(2 * N_SIZE - 2);
  localparam logic [CW-1:0] c_LAST_FLUSH = CW'(N_SIZE - 2);
  localparam logic [CW-1:0] c_ONE        = CW'(1);

  typedef enum logic [2:0] {
    S_LOAD  = 3'd0,
    S_CLEAR = 3'd1,
    S_FEED  = 3'd2,
    S_FLUSH = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                                         state_q, state_d;
  logic [CW-1:0]                                  cnt_q, cnt_d;
  logic [N_SIZE-1:0][N_SIZE-1:0][DATAWIDTH-1:0]   a_mem_q, b_mem_q;
  logic [N_SIZE-1:0][DATAWIDTH-1:0]               feed_a_q, feed_a_d;
  logic [N_SIZE-1:0][DATAWIDTH-1:0]               feed_b_q, feed_b_d;
  logic                                           feed_valid_q;
  logic                                           done_q;
  logic                                           clr_n_q;
  logic                                           w_load_fire;

  assign load_ready  = (state_q == S_LOAD);
  assign w_load_fire = (state_q == S_LOAD) && load_valid;

  // --------------------------------------------------------------------------
  // Next-state / counter logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_LOAD: begin
        if (load_valid) begin
          if (cnt_q == c_LAST_BEAT) begin
            state_d = S_CLEAR;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + c_ONE;
          end
        end
      end
      S_CLEAR: begin
        state_d = S_FEED;
        cnt_d   = '0;
      end
      S_FEED: begin
        if (cnt_q == c_LAST_STEP) begin
          state_d = S_FLUSH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + c_ONE;
        end
      end
      S_FLUSH: begin
        if (cnt_q == c_LAST_FLUSH) begin
          state_d = S_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + c_ONE;
        end
      end
      S_DONE: begin
        state_d = S_LOAD;
        cnt_d   = '0;
      end
      default: begin
        state_d = S_LOAD;
        cnt_d   = '0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Skewed operand selection for the step about to be presented. Row i sees
  // A[i][m] at step t = i+m; column j sees B[k][j] at step t = j+k. Looking
  // ahead at state_d/cnt_d lets the outputs come straight from flops while
  // still lining up with the FEED cycle they belong to.
  // --------------------------------------------------------------------------
  always_comb begin
    feed_a_d = '0;
    feed_b_d = '0;
    if (state_d == S_FEED) begin
      for (int i = 0; i < N_SIZE; i++) begin
        for (int m = 0; m < N_SIZE; m++) begin
          if (int'(cnt_d) == i + m) begin
            feed_a_d[i] = a_mem_q[i][m];
            feed_b_d[i] = b_mem_q[m][i];
          end
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // State, storage and registered outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_LOAD;
      cnt_q        <= '0;
      a_mem_q      <= '0;
      b_mem_q      <= '0;
      feed_a_q     <= '0;
      feed_b_q     <= '0;
      feed_valid_q <= 1'b0;
      done_q       <= 1'b0;
      clr_n_q      <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      feed_a_q     <= feed_a_d;
      feed_b_q     <= feed_b_d;
      feed_valid_q <= (state_d == S_FEED);
      done_q       <= (state_d == S_DONE);
      // Clear comes from its own flop so the PE reset never sees decode glitches.
      clr_n_q      <= (state_d != S_CLEAR);
      if (w_load_fire) begin
        for (int k = 0; k < N_SIZE; k++) begin
          if (int'(cnt_q) == k) begin
            a_mem_q[k] <= load_a;
            b_mem_q[k] <= load_b;
          end
        end
      end
    end
  end

  assign feed_a     = feed_a_q;
  assign feed_b     = feed_b_q;
  assign feed_valid = feed_valid_q;
  assign done       = done_q;
  assign acc_clr_n  = clr_n_q;

endmodule
`default_nettype wire
